// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : per-digit-slot scan phase (anti-ghost blanking, then drive)
//   SEG_BLANK    : all cathodes off (active-low)
//   HEX_SEG      : nibble -> gfedcba active-low pattern, index 0..15
package seg_pkg;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_controller_hex.sv
// hex_to_7seg: combinational nibble to seven-segment decoder.
//   nibble in  4  hex digit
//   segs   out 7  cathodes gfedcba, active-low
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes a 32-bit value onto an 8-digit
// seven-segment display as hex digits (digit 0 = least significant nibble).
// Updates go through a one-entry shadow register (valid/ready) and are only
// copied to the displayed value at frame boundaries, so a frame never tears.
//   clk          in   1           clock
//   rst          in   1           asynchronous reset, active-low
//   value_i      in   32          value to display
//   value_valid  in   1           value_i offered
//   value_ready  out  1           shadow register free
//   seg          out  NUM_DIGITS  anode enables, active-low
//   display      out  7           cathodes gfedcba, active-low
//   frame_done   out  1           pulse on the last cycle of the last digit
// Build option: define SEG_LZ_BLANK_EN for leading-zero suppression.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int REFRESH_HZ = 1_000,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value_i,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [NUM_DIGITS-1:0] seg,
  output logic [6:0]            display,
  output logic                  frame_done
);

  localparam int TICKS = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_t           state, state_nxt;
  logic [TW-1:0]         tick, tick_nxt;
  logic [DW-1:0]         digit, digit_nxt;
  logic [31:0]           active, pending;
  logic                  pending_full;
  logic                  wrap;
  logic                  lz;
  logic [3:0]            nibble;
  logic [6:0]            nib_seg;
  logic [NUM_DIGITS-1:0] seg_nxt;
  logic [6:0]            disp_nxt;

  assign nibble = active[{digit, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .nibble (nibble),
    .segs   (nib_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  // Blank when this and every more significant nibble is zero; digit 0 always shows.
  assign lz = (digit != '0) && ((active >> {digit, 2'b00}) == '0);
`else
  assign lz = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick + 1'b1;
    digit_nxt = digit;
    wrap      = 1'b0;
    seg_nxt   = '1;
    disp_nxt  = SEG_BLANK;
    case (state)
      S_BLANK: begin
        if (tick == TW'(BLANK_CYC - 1)) state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        seg_nxt  = ~(NUM_DIGITS'(1) << digit);
        disp_nxt = lz ? SEG_BLANK : nib_seg;
        if (tick == TW'(TICKS - 1)) begin
          tick_nxt  = '0;
          state_nxt = S_BLANK;
          if (digit == DW'(NUM_DIGITS - 1)) begin
            digit_nxt = '0;
            wrap      = 1'b1;
          end else begin
            digit_nxt = digit + 1'b1;
          end
        end
      end
      default: state_nxt = S_BLANK;
    endcase
  end

  // Pin outputs are registered, so they trail the scan state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_BLANK;
      tick    <= '0;
      digit   <= '0;
      seg     <= '1;
      display <= SEG_BLANK;
    end else begin
      state   <= state_nxt;
      tick    <= tick_nxt;
      digit   <= digit_nxt;
      seg     <= seg_nxt;
      display <= disp_nxt;
    end
  end

  // A load only happens while pending is empty, so it never collides with the
  // boundary transfer; a same-cycle load waits in pending for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (wrap && pending_full) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (value_valid && !pending_full) begin
      pending      <= value_i;
      pending_full <= 1'b1;
    end
  end

  assign value_ready = ~pending_full;
  assign frame_done  = wrap;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller (8 digits, 10-cycle slots,
// 2 blank cycles, 80-cycle frames). Expected values come from a cycle-count
// model of the scan and a two-register model of the snapshot handshake.
module tb_seg_scan_controller;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int ND    = 8;
  localparam int FRAME = SLOT * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value_i = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [7:0]  seg;
  logic [6:0]  display;
  logic        frame_done;

  seg_scan_controller #(
    .CLK_HZ     (800),
    .REFRESH_HZ (10),
    .NUM_DIGITS (8),
    .BLANK_CYC  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_i     (value_i),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg         (seg),
    .display     (display),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_fd = -1;
  logic [31:0] m_active = '0;
  logic [31:0] m_pend = '0;
  bit          m_full = 1'b0;
  bit          last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model at the edge, then check the registered pin outputs.
  task automatic step(input bit v, input logic [31:0] d);
    int         dig, pos;
    bit         drv, wrap, acc, lz;
    logic [7:0] e_seg;
    logic [6:0] e_disp;
    value_valid = v;
    value_i     = d;
    @(negedge clk);
    pos  = cyc % SLOT;
    dig  = (cyc / SLOT) % ND;
    drv  = pos >= BLANK;
    wrap = (pos == SLOT - 1) && (dig == ND - 1);
`ifdef SEG_LZ_BLANK_EN
    lz = (dig > 0) && ((m_active >> (4 * dig)) == 0);
`else
    lz = 1'b0;
`endif
    chk("value_ready", {31'b0, value_ready}, {31'b0, !m_full});
    chk("frame_done", {31'b0, frame_done}, {31'b0, wrap});
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("frame_period", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
    e_seg  = drv ? ~(8'b1 << dig) : 8'hFF;
    e_disp = (drv && !lz) ? hex_tab[(m_active >> (4 * dig)) & 32'hF] : 7'h7F;
    acc    = v && !m_full;
    @(posedge clk);
    if (wrap && m_full) begin
      m_active = m_pend;
      m_full   = 1'b0;
    end
    if (acc) begin
      m_pend = d;
      m_full = 1'b1;
    end
    last_acc = acc;
    cyc++;
    #1;
    chk("seg", {24'b0, seg}, {24'b0, e_seg});
    chk("display", {25'b0, display}, {25'b0, e_disp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom);
  endtask

  // Producer holds the value until it is taken, bounded.
  task automatic offer(input logic [31:0] d);
    int n = 0;
    do begin
      step(1'b1, d);
      n++;
    end while (!last_acc && n < 3 * FRAME);
    value_valid = 1'b0;
    if (!last_acc) begin
      checks++;
      failures++;
      $error("FAIL offer_timeout observed=not_taken expected=taken value=%h", d);
    end
  endtask

  task automatic run_to_phase(input int ph);
    int n = 0;
    while ((cyc % FRAME) != ph && n < 2 * FRAME) begin
      step(1'b0, '0);
      n++;
    end
  endtask

  initial begin
    // 1: reset hold, then release
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {24'b0, seg}, 32'hFF);
    chk("rst_display", {25'b0, display}, 32'h7F);
    chk("rst_ready", {31'b0, value_ready}, 32'h1);
    chk("rst_frame_done", {31'b0, frame_done}, 32'h0);
    rst = 1'b1;
    idle(SLOT);

    // 2: load a value, watch full frames
    offer(32'h89AB_CDEF);
    idle(2 * FRAME);

    // 3: A pending, B held off until the boundary frees the shadow register
    offer(32'h1234_5678);
    step(1'b1, 32'hFEDC_BA98);
    chk("b_not_taken", {31'b0, last_acc}, 32'h0);
    offer(32'hFEDC_BA98);
    idle(2 * FRAME);

    // 4: load on the exact wrap cycle with pending empty
    run_to_phase(FRAME - 1);
    step(1'b1, 32'h0000_0003);
    chk("wrap_load_taken", {31'b0, last_acc}, 32'h1);
    idle(2 * FRAME + 5);

    // 5: reset mid-drive on digit 5 with a value pending
    run_to_phase(0);
    idle(SLOT);
    offer(32'h7777_7777);
    run_to_phase(5 * SLOT + 5);
    rst = 1'b0;
    #1;
    chk("arst_seg", {24'b0, seg}, 32'hFF);
    chk("arst_display", {25'b0, display}, 32'h7F);
    chk("arst_ready", {31'b0, value_ready}, 32'h1);
    chk("arst_frame_done", {31'b0, frame_done}, 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    cyc      = 0;
    last_fd  = -1;
    m_active = '0;
    m_pend   = '0;
    m_full   = 1'b0;
    idle(FRAME + 5);

    // 6: leading-zero patterns (blanked only when built with suppression)
    offer(32'h0000_00A5);
    idle(2 * FRAME);
    offer(32'h0000_0000);
    idle(2 * FRAME);

    // randomized traffic
    for (int i = 0; i < 6 * FRAME; i++) step($urandom_range(0, 7) == 0, $urandom);
    idle(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
